// File: rtl/ham_pkg.sv
// ham_pkg: Hamming(7,4) widths, types and encode helpers shared by encoder, decoder and benches.
package ham_pkg;
  localparam int HAM_K = 4;
  localparam int HAM_N = 7;
  typedef logic [HAM_K-1:0] ham_data_t;
  typedef logic [HAM_N-1:0] ham_code_t;
  // Bit index = Hamming position - 1; parity at positions 1, 2 and 4.
  function automatic ham_code_t ham_encode(ham_data_t d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction
  function automatic ham_code_t ham_inj_mask(logic [2:0] pos);
    ham_code_t m;
    m = '0;
    for (int k = 0; k < HAM_N; k++) m[k] = (pos == 3'(k + 1));
    return m;
  endfunction
endpackage

// File: rtl/ham_skid_fifo2.sv
// ham_skid_fifo2: 2-entry valid/ready queue (head + skid), all outputs from registered state.
module ham_skid_fifo2 #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] head_q, head_d, skid_q, skid_d;
  logic         rdy_q;
  logic         push, pop;
  assign in_ready  = rdy_q & (occ_q != 2'd2);
  assign out_valid = occ_q != 2'd0;
  assign out_data  = head_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  // Head is only ever written from a handshaked input or the skid entry.
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    if (occ_q == 2'd2) begin
      head_d = pop ? skid_q : head_q;
      occ_d  = pop ? 2'd1 : 2'd2;
    end else if (push && (occ_q == 2'd0 || pop)) begin
      head_d = in_data;
      occ_d  = 2'd1;
    end else if (push) begin
      skid_d = in_data;
      occ_d  = 2'd2;
    end else if (pop) begin
      occ_d  = 2'd0;
    end
  end
  // rdy_q keeps in_ready low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      skid_q <= skid_d;
      rdy_q  <= 1'b1;
    end
  end
endmodule

// File: rtl/ham_encoder_tx.sv
// ham_encoder_tx: streaming Hamming(7,4) encoder with error injection, 2-entry output queue
// and a wrapping accepted-codeword counter with sticky overflow flag.
module ham_encoder_tx
  import ham_pkg::*;
#(
  parameter bit ENABLE_INJ = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [2:0]       in_inj_pos,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  output logic [CNT_W-1:0] cw_count,
  output logic             overflow_seen
);
  ham_code_t        code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             pop;
  assign code_d = ham_encode(in_data) ^ (ENABLE_INJ ? ham_inj_mask(in_inj_pos) : '0);
  ham_skid_fifo2 #(.W(HAM_N)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (code_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_code)
  );
  assign pop = out_valid & out_ready;
  always_comb begin
    cnt_d = cnt_q + CNT_W'(pop);
    ovf_d = ovf_q | (pop & (&cnt_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign cw_count      = cnt_q;
  assign overflow_seen = ovf_q;
endmodule

// File: tb/tb_ham_encoder_tx.sv
// tb_ham_encoder_tx: directed and randomized checks of ham_encoder_tx against a position-based
// Hamming model and a queue scoreboard; a second instance covers ENABLE_INJ=0 and a 4-bit counter.
module tb_ham_encoder_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic [2:0]  in_inj_pos = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, overflow_seen;
  logic [6:0]  out_code;
  logic [15:0] cw_count;
  logic        s_in_ready, s_out_valid, s_overflow;
  logic [6:0]  s_out_code;
  logic [3:0]  s_cw_count;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  ham_encoder_tx dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inj_pos(in_inj_pos), .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .cw_count(cw_count), .overflow_seen(overflow_seen)
  );
  ham_encoder_tx #(.ENABLE_INJ(1'b0), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .in_inj_pos(in_inj_pos), .out_valid(s_out_valid), .out_ready(out_ready), .out_code(s_out_code),
    .cw_count(s_cw_count), .overflow_seen(s_overflow)
  );

  // Data bits go to positions 3,5,6,7; parity bits make the XOR of all set positions zero.
  function automatic logic [6:0] ref_enc(logic [3:0] d);
    logic [6:0] c = '0;
    logic [2:0] s = '0;
    int dp [4] = '{3, 5, 6, 7};
    for (int i = 0; i < 4; i++) if (d[i]) begin c[dp[i]-1] = 1'b1; s ^= 3'(dp[i]); end
    c[0] = s[0]; c[1] = s[1]; c[3] = s[2];
    return c;
  endfunction
  function automatic logic [2:0] syndrome(logic [6:0] c);
    logic [2:0] s = '0;
    for (int p = 1; p <= 7; p++) if (c[p-1]) s ^= 3'(p);
    return s;
  endfunction
  function automatic logic [6:0] flip(logic [6:0] c, int pos);
    return pos == 0 ? c : c ^ (7'(1) << (pos - 1));
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inj_pos = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_code !== 7'h00) begin n_bad++; $display("FAIL reset_out_code: got %h expected 00", out_code); end
    n_cmp++; if (cw_count !== 16'd0 || overflow_seen !== 1'b0) begin n_bad++; $display("FAIL reset_count: got %0d/%b expected 0/0", cw_count, overflow_seen); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL release_in_ready_low: got %b expected 0", in_ready); end
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready_high: got %b expected 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [3:0] vd [6] = '{4'hB, 4'h0, 4'hF, 4'h1, 4'hB, 4'hB};
    logic [2:0] vp [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd7};
    logic [6:0] ve [6] = '{7'h55, 7'h00, 7'h7F, 7'h07, 7'h51, 7'h15};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = vd[i]; in_inj_pos = vp[i];
      step();
      in_valid = 1'b0; in_inj_pos = '0;
      n_cmp++; if (out_valid !== 1'b1 || out_code !== ve[i]) begin n_bad++; $display("FAIL vector_%0d: got v=%b code=%h expected v=1 code=%h", i, out_valid, out_code, ve[i]); end
      n_cmp++; if (syndrome(out_code) !== 3'(vp[i])) begin n_bad++; $display("FAIL vector_syndrome_%0d: got %0d expected %0d", i, syndrome(out_code), vp[i]); end
      if (vp[i] == 3'd3) begin
        n_cmp++; if (s_out_code !== 7'h55) begin n_bad++; $display("FAIL inj_disabled: got %h expected 55", s_out_code); end
      end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL vector_drain_%0d: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_all16();
    logic [3:0] d;
    apply_reset();
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        d = 4'(i - 1);
        n_cmp++; if (out_valid !== 1'b1 || out_code !== ref_enc(d)) begin n_bad++; $display("FAIL all16_%0d: got v=%b code=%h expected v=1 code=%h", i - 1, out_valid, out_code, ref_enc(d)); end
        n_cmp++; if (syndrome(out_code) !== 3'd0 || {out_code[6:4], out_code[2]} !== d) begin n_bad++; $display("FAIL all16_decode_%0d: got syn=%0d data=%h expected 0/%h", i - 1, syndrome(out_code), {out_code[6:4], out_code[2]}, d); end
      end
      in_valid = (i < 16); in_data = 4'(i);
      if (i < 16) step();
    end
    step();
    n_cmp++; if (cw_count !== 16'd16 || out_valid !== 1'b0) begin n_bad++; $display("FAIL all16_count: got %0d v=%b expected 16 v=0", cw_count, out_valid); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h1;
    step();
    n_cmp++; if (in_ready !== 1'b1 || out_code !== 7'h07) begin n_bad++; $display("FAIL bp_first: got rdy=%b code=%h expected 1/07", in_ready, out_code); end
    in_data = 4'h2;
    step();
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0 || out_code !== 7'h07) begin n_bad++; $display("FAIL bp_full: got rdy=%b code=%h expected 0/07", in_ready, out_code); end
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b1 || out_code !== 7'h07) begin n_bad++; $display("FAIL bp_hold: got v=%b code=%h expected 1/07", out_valid, out_code); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_code !== 7'h19 || in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_second: got v=%b code=%h rdy=%b expected 1/19/1", out_valid, out_code, in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || cw_count !== 16'd2) begin n_bad++; $display("FAIL bp_empty: got v=%b cnt=%0d expected 0/2", out_valid, cw_count); end
  endtask

  task automatic test_random();
    logic [6:0] q [$];
    logic [6:0] prev = '0;
    logic       stalled = 1'b0;
    int sent = 0, got = 0, cyc = 0;
    apply_reset();
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      @(posedge clk); #1;
      in_valid   = (sent < 1000) && ($urandom_range(3) != 0);
      in_data    = 4'($urandom);
      in_inj_pos = ($urandom_range(3) == 0) ? 3'($urandom_range(7, 1)) : 3'd0;
      out_ready  = $urandom_range(2) != 0;
      @(negedge clk);
      cyc++;
      n_cmp++; if (in_ready !== (q.size() < 2)) begin n_bad++; $display("FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, in_ready, q.size() < 2); end
      n_cmp++; if (out_valid !== (q.size() > 0)) begin n_bad++; $display("FAIL rand_out_valid cyc %0d: got %b expected %b", cyc, out_valid, q.size() > 0); end
      if (out_valid && q.size() > 0) begin
        n_cmp++; if (out_code !== q[0]) begin n_bad++; $display("FAIL rand_code cyc %0d: got %h expected %h", cyc, out_code, q[0]); end
      end
      if (stalled && out_valid) begin
        n_cmp++; if (out_code !== prev) begin n_bad++; $display("FAIL rand_stable cyc %0d: got %h expected %h", cyc, out_code, prev); end
      end
      stalled = out_valid && !out_ready;
      prev = out_code;
      if (out_valid && out_ready && q.size() > 0) begin void'(q.pop_front()); got++; end
      if (in_valid && in_ready) begin q.push_back(flip(ref_enc(in_data), int'(in_inj_pos))); sent++; end
    end
    in_valid = 1'b0; in_inj_pos = '0; out_ready = 1'b1;
    n_cmp++; if (got != 1000 || cyc >= 20000) begin n_bad++; $display("FAIL rand_total: got %0d received in %0d cycles expected 1000", got, cyc); end
  endtask

  task automatic test_reset_mid();
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h6;
    step(); step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || cw_count == 16'd0) begin n_bad++; $display("FAIL mid_full: got v=%b rdy=%b cnt=%0d expected 1/0/nonzero", out_valid, in_ready, cw_count); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || cw_count !== 16'd0 || in_ready !== 1'b0 || out_code !== 7'h00) begin n_bad++; $display("FAIL mid_async: got v=%b cnt=%0d rdy=%b code=%h expected 0/0/0/00", out_valid, cw_count, in_ready, out_code); end
    @(negedge clk) rst_n = 1'b1; out_ready = 1'b1;
    repeat (4) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_no_emit: got %b expected 0", out_valid); end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin in_data = 4'($urandom); step(); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (s_cw_count !== 4'd1 || s_overflow !== 1'b1) begin n_bad++; $display("FAIL wrap_small: got %0d/%b expected 1/1", s_cw_count, s_overflow); end
    n_cmp++; if (cw_count !== 16'd17 || overflow_seen !== 1'b0) begin n_bad++; $display("FAIL wrap_main: got %0d/%b expected 17/0", cw_count, overflow_seen); end
    repeat (3) step();
    n_cmp++; if (s_overflow !== 1'b1) begin n_bad++; $display("FAIL wrap_sticky: got %b expected 1", s_overflow); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_all16();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ham_encoder_tx.md
Name: ham_encoder_tx

Overview:
Streaming Hamming(7,4) encoder. It is the transmit-side counterpart of the team's ham_decoder.
- Accepts 4-bit data nibbles over a valid/ready handshake.
- Computes the 7-bit codeword in the same bit layout the decoder consumes.
- Buffers codewords in a 2-entry output queue, so backpressure never creates a combinational path.
- Provides a per-nibble error-injection hook and an accepted-codeword counter, for link bring-up and decoder verification.

Parameters:
- ENABLE_INJ, 1, 1 = honour in_inj_pos; 0 = injection logic tied off and in_inj_pos ignored.
- CNT_W, 16, width of the codeword counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset. One clock domain; reset is asynchronous and active-low.
- in_valid  input  1  nibble present.
- in_ready  output  1  encoder can accept this cycle.
- in_data  input  4  data nibble d[3:0].
- in_inj_pos  input  3  0 = no error; 1..7 = flip codeword position k (bit k-1) before queueing.
- out_valid  output  1  codeword available.
- out_ready  input  1  downstream accepts.
- out_code  output  7  codeword, bit index = Hamming position minus 1.
- cw_count  output  CNT_W  number of codewords accepted downstream (out_valid & out_ready); wraps.
- overflow_seen  output  1  sticky flag: cw_count wrapped at least once.

Behaviour:
- Encoding, from input d, producing code c:
  - c[0] = p1 = d0^d1^d3
  - c[1] = p2 = d0^d2^d3
  - c[2] = d0
  - c[3] = p4 = d1^d2^d3
  - c[4] = d1
  - c[5] = d2
  - c[6] = d3
- Injection: when ENABLE_INJ = 1 and in_inj_pos = k ≠ 0, c[k-1] is inverted. The flip is applied at push time and captured with the entry.
- Handshake:
  - Input transfer occurs on in_valid & in_ready; output transfer occurs on out_valid & out_ready.
  - in_valid may be held indefinitely. in_data and in_inj_pos are sampled only on a transfer.
- Queue:
  - Two entries: a head register driving out_code, plus one skid register. Occupancy is 0, 1 or 2.
  - in_ready = (occupancy < 2). It is a pure function of registered state, with no dependence on out_ready.
  - out_valid = (occupancy > 0). out_code is taken directly from the head register, with no combinational logic after it.
- Latency: a nibble accepted at edge N, with the queue empty, gives out_valid = 1 and the correct out_code in the cycle after edge N. Minimum latency is 1 cycle.
- Throughput: 1 codeword/cycle sustained while out_ready = 1.
- Simultaneous push and pop:
  - occupancy 1: head is replaced by the new codeword; occupancy stays 1.
  - occupancy 2: impossible, because in_ready = 0.
  - occupancy 0: pop is impossible (out_valid = 0); push only.
- Pop with occupancy 2: the skid entry moves to head, in order. The queue is strict FIFO; no reordering.
- Stability: while out_valid = 1 and out_ready = 0, out_code must hold stable.
- Counter: cw_count increments by 1 per output transfer and wraps from 2^CNT_W-1 to 0. On that wrap, overflow_seen sets and stays set until reset.
- Reset, asynchronous, while rst_n = 0:
  - occupancy 0, out_valid = 0, in_ready = 0, out_code = 0, cw_count = 0, overflow_seen = 0.
  - in_ready rises on the first clock edge after rst_n deasserts.
  - Reset mid-stream discards all queued codewords; nothing is emitted after release until new input arrives.
- X safety: out_code is don't-care when out_valid = 0, but the register must never be loaded from an un-handshaked input.

Decomposition:
- Shared package ham_pkg holds:
  - localparams HAM_K = 4, HAM_N = 7.
  - typedefs ham_data_t (logic [3:0]) and ham_code_t (logic [6:0]).
  - function ham_encode(ham_data_t) returning ham_code_t. The same function is reused by the bench scoreboard.
- One natural sub-module, ham_skid_fifo2: a parameterised-width 2-entry valid/ready queue. The encoder instantiates it with width HAM_N.

Test Plan:
- Codeword values, with out_ready = 1 and inj_pos = 0:
  - in_data 4'hB -> out_code 7'h55, one cycle later.
  - 4'h0 -> 7'h00.
  - 4'hF -> 7'h7F.
  - 4'h1 -> 7'h07.
- All 16 nibbles back-to-back, out_ready = 1 -> 16 consecutive out_valid cycles, each matching ham_encode; cw_count = 16. Each codeword looped into ham_decoder gives error = 0 and the original data.
- Injection: in_data 4'hB with inj_pos 3 -> out_code 7'h51; the decoder reports pos_error = 3. inj_pos 7 -> 7'h15. With ENABLE_INJ = 0, inj_pos 3 -> 7'h55.
- Backpressure:
  - out_ready = 0, push 4'h1 then 4'h2 -> in_ready drops after the second accept; out_code holds 7'h07.
  - Release out_ready -> outputs 7'h07 then ham_encode(4'h2) in order; in_ready re-asserts.
- Random valid/ready toggling over 1000 nibbles -> no drops, no duplicates, order preserved, out_code stable while stalled.
- Reset and wrap:
  - Assert rst_n = 0 with 2 entries queued -> out_valid = 0 and cw_count = 0 immediately (async).
  - With CNT_W = 4, 17 transfers -> cw_count = 1 and overflow_seen = 1.
